// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Recovers the hex nibble shown on each digit of a 4-digit multiplexed,
// active-low seven-segment display. A digit's pattern is committed only
// after STABLE_COUNT consecutive identical valid observations.
//
// Ports:
//   Clk         system clock, all state on rising edge
//   Rst         synchronous, active-high reset
//   sample_en   observation strobe
//   dig_en      active-low digit enables (exactly one low = valid)
//   seg_in      active-low segments {g,f,e,d,c,b,a}
//   digits_out  committed nibbles, digit i at [4i+3:4i]
//   blank_mask  bit i high = digit i committed blank
//   upd         one-cycle pulse: a committed digit changed
//   upd_digit   index of the changed digit, valid with upd
//   err         one-cycle pulse: a stable illegal pattern was seen
//   err_digit   index for err, valid with err
module seg7_scan_decoder #(
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        sample_en,
    input  logic [3:0]  dig_en,
    input  logic [6:0]  seg_in,
    output logic [15:0] digits_out,
    output logic [3:0]  blank_mask,
    output logic        upd,
    output logic [1:0]  upd_digit,
    output logic        err,
    output logic [1:0]  err_digit
);

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned NIB_W      = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = SEG_W'(7'h7F);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_COUNT);

    typedef struct packed {
        logic             legal;
        logic             blank;
        logic [NIB_W-1:0] nib;
    } dec_t;

    // Segment pattern to nibble; blank is legal and reads as nibble 0.
    function automatic dec_t decode_seg(input logic [SEG_W-1:0] seg);
        dec_t r;
        r.legal = 1'b1;
        r.blank = 1'b0;
        r.nib   = '0;
        case (seg)
            7'b1000000: r.nib = 4'h0;
            7'b1111001: r.nib = 4'h1;
            7'b0100100: r.nib = 4'h2;
            7'b0110000: r.nib = 4'h3;
            7'b0011001: r.nib = 4'h4;
            7'b0010010: r.nib = 4'h5;
            7'b0000010: r.nib = 4'h6;
            7'b1111000: r.nib = 4'h7;
            7'b0000000: r.nib = 4'h8;
            7'b0011000: r.nib = 4'h9;
            7'b0001000: r.nib = 4'hA;
            7'b0000011: r.nib = 4'hB;
            7'b1000110: r.nib = 4'hC;
            7'b0100001: r.nib = 4'hD;
            7'b0000110: r.nib = 4'hE;
            7'b0001110: r.nib = 4'hF;
            7'b1111111: r.blank = 1'b1;
            default:    r.legal = 1'b0;
        endcase
        return r;
    endfunction

    logic [SEG_W-1:0] cand_q [NUM_DIGITS];
    logic [SEG_W-1:0] cand_d [NUM_DIGITS];
    logic [CNT_W-1:0] cnt_q  [NUM_DIGITS];
    logic [CNT_W-1:0] cnt_d  [NUM_DIGITS];
    logic [SEG_W-1:0] comm_q [NUM_DIGITS];
    logic [SEG_W-1:0] comm_d [NUM_DIGITS];

    logic [15:0]      digits_q, digits_d;
    logic [3:0]       blank_q, blank_d;
    logic             upd_q, upd_d;
    logic [IDX_W-1:0] upd_digit_q, upd_digit_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_digit_q, err_digit_d;

    logic             obs_valid;
    logic [IDX_W-1:0] obs_idx;
    logic [CNT_W-1:0] new_cnt;
    logic             reached;
    dec_t             seg_dec;

    // Stability counting and commit decision for the observed digit.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        comm_d      = comm_q;
        digits_d    = digits_q;
        blank_d     = blank_q;
        upd_d       = 1'b0;
        upd_digit_d = upd_digit_q;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        obs_valid   = 1'b0;
        obs_idx     = '0;
        new_cnt     = '0;
        reached     = 1'b0;
        seg_dec     = decode_seg(seg_in);

        case (dig_en)
            4'b1110: begin obs_valid = sample_en; obs_idx = IDX_W'(0); end
            4'b1101: begin obs_valid = sample_en; obs_idx = IDX_W'(1); end
            4'b1011: begin obs_valid = sample_en; obs_idx = IDX_W'(2); end
            4'b0111: begin obs_valid = sample_en; obs_idx = IDX_W'(3); end
            default: ;
        endcase

        if (obs_valid) begin
            // "reached" means the count hits the threshold this cycle,
            // so a saturated count never re-fires.
            if (seg_in != cand_q[obs_idx]) begin
                cand_d[obs_idx] = seg_in;
                new_cnt         = CNT_ONE;
                reached         = (CNT_ONE == CNT_MAX);
            end else if (cnt_q[obs_idx] == CNT_MAX) begin
                new_cnt = CNT_MAX;
            end else begin
                new_cnt = cnt_q[obs_idx] + CNT_ONE;
                reached = (new_cnt == CNT_MAX);
            end
            cnt_d[obs_idx] = new_cnt;

            if (reached && (seg_in != comm_q[obs_idx])) begin
                if (seg_dec.legal) begin
                    comm_d[obs_idx]                    = seg_in;
                    digits_d[{obs_idx, 2'b00} +: NIB_W] = seg_dec.nib;
                    blank_d[obs_idx]                   = seg_dec.blank;
                    upd_d                              = 1'b1;
                    upd_digit_d                        = obs_idx;
                end else begin
                    err_d       = 1'b1;
                    err_digit_d = obs_idx;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_q[i] <= SEG_BLANK;
                cnt_q[i]  <= '0;
                comm_q[i] <= SEG_BLANK;
            end
            digits_q    <= '0;
            blank_q     <= 4'hF;
            upd_q       <= 1'b0;
            upd_digit_q <= '0;
            err_q       <= 1'b0;
            err_digit_q <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_q[i] <= cand_d[i];
                cnt_q[i]  <= cnt_d[i];
                comm_q[i] <= comm_d[i];
            end
            digits_q    <= digits_d;
            blank_q     <= blank_d;
            upd_q       <= upd_d;
            upd_digit_q <= upd_digit_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign digits_out = digits_q;
    assign blank_mask = blank_q;
    assign upd        = upd_q;
    assign upd_digit  = upd_digit_q;
    assign err        = err_q;
    assign err_digit  = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: table-driven vectors checked through a
// scoreboard queue, plus a short sequence on a STABLE_COUNT=1 instance.
module tb_seg7_scan_decoder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [3:0]  dig_en = 4'hF;
    logic [6:0]  seg_in = 7'h7F;

    logic [15:0] digits_out, digits_out1;
    logic [3:0]  blank_mask, blank_mask1;
    logic        upd, upd1, err, err1;
    logic [1:0]  upd_digit, upd_digit1, err_digit, err_digit1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    seg7_scan_decoder #(.STABLE_COUNT(4)) u_dut (
        .Clk(Clk), .Rst(Rst), .sample_en(sample_en), .dig_en(dig_en),
        .seg_in(seg_in), .digits_out(digits_out), .blank_mask(blank_mask),
        .upd(upd), .upd_digit(upd_digit), .err(err), .err_digit(err_digit)
    );

    seg7_scan_decoder #(.STABLE_COUNT(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .sample_en(sample_en), .dig_en(dig_en),
        .seg_in(seg_in), .digits_out(digits_out1), .blank_mask(blank_mask1),
        .upd(upd1), .upd_digit(upd_digit1), .err(err1), .err_digit(err_digit1)
    );

    typedef struct {
        logic        rst;
        logic        se;
        logic [3:0]  den;
        logic [6:0]  seg;
        logic        eu;
        logic [1:0]  eud;
        logic        ee;
        logic [1:0]  eed;
        logic [15:0] dig;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic add(input logic rst, input logic se, input logic [3:0] den,
                       input logic [6:0] seg, input logic eu, input logic [1:0] eud,
                       input logic ee, input logic [1:0] eed,
                       input logic [15:0] dig, input logic [3:0] blank);
        vec_t v;
        v.rst = rst; v.se = se; v.den = den; v.seg = seg;
        v.eu = eu; v.eud = eud; v.ee = ee; v.eed = eed;
        v.dig = dig; v.blank = blank;
        vecs.push_back(v);
    endtask

    // n observations expected to produce no pulse and leave outputs as given
    task automatic idle(input int n, input logic se, input logic [3:0] den,
                        input logic [6:0] seg, input logic [15:0] dig,
                        input logic [3:0] blank);
        for (int i = 0; i < n; i++) add(1'b0, se, den, seg, 1'b0, 2'd0, 1'b0, 2'd0, dig, blank);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic se, input logic [3:0] den,
                         input logic [6:0] seg);
        @(negedge Clk);
        Rst = rst; sample_en = se; dig_en = den; seg_in = seg;
    endtask

    initial begin
        vec_t e;

        // reset
        add(1'b1, 1'b0, 4'hF, 7'h7F, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'hF);
        // digit 0 shows 3
        idle(3, 1'b1, 4'hE, 7'h30, 16'h0000, 4'hF);
        add(1'b0, 1'b1, 4'hE, 7'h30, 1'b1, 2'd0, 1'b0, 2'd0, 16'h0003, 4'hE);
        // digit 2: A interrupted by b
        idle(3, 1'b1, 4'hB, 7'h08, 16'h0003, 4'hE);
        idle(3, 1'b1, 4'hB, 7'h03, 16'h0003, 4'hE);
        add(1'b0, 1'b1, 4'hB, 7'h03, 1'b1, 2'd2, 1'b0, 2'd0, 16'h0B03, 4'hA);
        // digit 1: 2, then held past saturation
        idle(3, 1'b1, 4'hD, 7'h24, 16'h0B03, 4'hA);
        add(1'b0, 1'b1, 4'hD, 7'h24, 1'b1, 2'd1, 1'b0, 2'd0, 16'h0B23, 4'h8);
        idle(4, 1'b1, 4'hD, 7'h24, 16'h0B23, 4'h8);
        // digit 3: illegal, then blank (already committed)
        idle(3, 1'b1, 4'h7, 7'h7E, 16'h0B23, 4'h8);
        add(1'b0, 1'b1, 4'h7, 7'h7E, 1'b0, 2'd0, 1'b1, 2'd3, 16'h0B23, 4'h8);
        idle(4, 1'b1, 4'h7, 7'h7F, 16'h0B23, 4'h8);
        // illegal again after interruption, no repeat while held, then 5
        idle(3, 1'b1, 4'h7, 7'h7E, 16'h0B23, 4'h8);
        add(1'b0, 1'b1, 4'h7, 7'h7E, 1'b0, 2'd0, 1'b1, 2'd3, 16'h0B23, 4'h8);
        idle(2, 1'b1, 4'h7, 7'h7E, 16'h0B23, 4'h8);
        idle(3, 1'b1, 4'h7, 7'h12, 16'h0B23, 4'h8);
        add(1'b0, 1'b1, 4'h7, 7'h12, 1'b1, 2'd3, 1'b0, 2'd0, 16'h5B23, 4'h0);
        // digit 0 partial count survives invalid cycles
        idle(2, 1'b1, 4'hE, 7'h40, 16'h5B23, 4'h0);
        idle(3, 1'b1, 4'hC, 7'h12, 16'h5B23, 4'h0);
        idle(3, 1'b1, 4'hF, 7'h08, 16'h5B23, 4'h0);
        idle(4, 1'b0, 4'hE, 7'h12, 16'h5B23, 4'h0);
        idle(1, 1'b1, 4'hE, 7'h40, 16'h5B23, 4'h0);
        add(1'b0, 1'b1, 4'hE, 7'h40, 1'b1, 2'd0, 1'b0, 2'd0, 16'h5B20, 4'h0);
        // reset after 3 of 4 samples discards everything
        idle(3, 1'b1, 4'hE, 7'h30, 16'h5B20, 4'h0);
        add(1'b1, 1'b1, 4'hE, 7'h30, 1'b0, 2'd0, 1'b0, 2'd0, 16'h0000, 4'hF);
        idle(3, 1'b1, 4'hE, 7'h30, 16'h0000, 4'hF);
        add(1'b0, 1'b1, 4'hE, 7'h30, 1'b1, 2'd0, 1'b0, 2'd0, 16'h0003, 4'hE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].se, vecs[i].den, vecs[i].seg);
            exp_q.push_back(vecs[i]);
            @(posedge Clk);
            #1;
            e = exp_q.pop_front();
            chk("upd", i, 16'(upd), 16'(e.eu));
            chk("err", i, 16'(err), 16'(e.ee));
            chk("digits_out", i, digits_out, e.dig);
            chk("blank_mask", i, 16'(blank_mask), 16'(e.blank));
            if (e.eu) chk("upd_digit", i, 16'(upd_digit), 16'(e.eud));
            if (e.ee) chk("err_digit", i, 16'(err_digit), 16'(e.eed));
        end

        // STABLE_COUNT = 1: commit on the first valid observation
        drive(1'b1, 1'b0, 4'hF, 7'h7F);
        @(posedge Clk); #1;
        chk("n1_reset_blank", 0, 16'(blank_mask1), 16'hF);
        drive(1'b0, 1'b1, 4'hD, 7'h24);
        @(posedge Clk); #1;
        chk("n1_upd_first", 1, 16'(upd1), 16'h1);
        chk("n1_upd_digit", 1, 16'(upd_digit1), 16'h1);
        chk("n1_digits", 1, digits_out1, 16'h0020);
        chk("n4_no_upd_first", 1, 16'(upd), 16'h0);
        drive(1'b0, 1'b1, 4'hD, 7'h24);
        @(posedge Clk); #1;
        chk("n1_no_repeat", 2, 16'(upd1), 16'h0);
        drive(1'b0, 1'b1, 4'hD, 7'h30);
        @(posedge Clk); #1;
        chk("n1_upd_change", 3, 16'(upd1), 16'h1);
        chk("n1_digits_change", 3, digits_out1, 16'h0030);
        chk("n1_blank", 3, 16'(blank_mask1), 16'hD);
        drive(1'b0, 1'b1, 4'hD, 7'h7E);
        @(posedge Clk); #1;
        chk("n1_err", 4, 16'(err1), 16'h1);
        chk("n1_err_digit", 4, 16'(err_digit1), 16'h1);
        chk("n1_digits_kept", 4, digits_out1, 16'h0030);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
